// File: rtl/pcm_pwm_modulator.sv
// PCM-to-PWM audio modulator: valid/ready sample input, small FIFO, PWM pin and amp enable.
// Define PCM_PWM_SIGNED_EN to accept two's-complement samples (converted to offset-binary on write).
module pcm_pwm_modulator #(
    parameter int SAMPLE_W   = 8,
    parameter int REPEAT     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic                aud_pwm_o,
    output logic                aud_sd_o,
    output logic                sample_tick_o,
    output logic                underrun_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
    localparam logic [SAMPLE_W-1:0] MID_DUTY = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [REP_W-1:0]    REP_LAST = REP_W'(REPEAT - 1);
    localparam logic [CNT_W-1:0]    FIFO_CAP = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SAMPLE_W-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [SAMPLE_W-1:0]  duty_q, duty_d;
    logic                 pwm_q, pwm_d;
    logic                 tick_q, tick_d;
    logic                 underrun_q, underrun_d;

    logic [SAMPLE_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic                 full_q, full_d;

    logic                 s_ready;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 fifo_empty;
    logic                 boundary;
    logic [SAMPLE_W-1:0]  wr_data;
    logic [SAMPLE_W-1:0]  rd_data;

`ifdef PCM_PWM_SIGNED_EN
    assign wr_data = {~s_data_i[SAMPLE_W-1], s_data_i[SAMPLE_W-2:0]};
`else
    assign wr_data = s_data_i;
`endif

    // Samples are refused in IDLE because IDLE flushes the FIFO every cycle.
    assign s_ready    = en_i & ~full_q & (state_q != IDLE) & ~rst_i;
    assign push       = s_valid_i & s_ready;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign rd_data    = fifo_mem_q[rd_ptr_q];
    assign boundary   = (cnt_q == CNT_MAX) && (rep_q == REP_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        duty_d     = duty_q;
        tick_d     = 1'b0;
        underrun_d = underrun_q;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                rep_d      = '0;
                underrun_d = 1'b0;
                flush      = 1'b1;
                if (en_i) begin
                    state_d = PRIME;
                end
            end

            PRIME: begin
                cnt_d = '0;
                rep_d = '0;
                if (!en_i) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    duty_d  = rd_data;
                    tick_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                cnt_d = cnt_q + SAMPLE_W'(1);
                if (cnt_q == CNT_MAX) begin
                    rep_d = (rep_q == REP_LAST) ? '0 : rep_q + REP_W'(1);
                end
                // Disable only takes effect here so the last period is never truncated.
                if (boundary) begin
                    if (!en_i) begin
                        state_d = IDLE;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        duty_d = rd_data;
                        tick_d = 1'b1;
                    end else begin
                        duty_d     = MID_DUTY;
                        underrun_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pwm_d = (state_q == RUN) && (cnt_q < duty_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    assign full_d = (fifo_cnt_d == FIFO_CAP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rep_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign s_ready_o     = s_ready;
    assign aud_pwm_o     = pwm_q;
    assign aud_sd_o      = (state_q != IDLE);
    assign sample_tick_o = tick_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_pcm_pwm_modulator.sv
// Self-checking bench for pcm_pwm_modulator (SAMPLE_W=8, REPEAT=2, FIFO_DEPTH=4).
// Per-period PWM high counts are scored against a queue filled as samples are accepted.
module tb_pcm_pwm_modulator;

    localparam int SW     = 8;
    localparam int RP     = 2;
    localparam int FD     = 4;
    localparam int PERIOD = 256;

    logic          clk;
    logic          rst;
    logic          en;
    logic [SW-1:0] sData;
    logic          sValid;
    logic          sReady;
    logic          audPwm;
    logic          audSd;
    logic          sampleTick;
    logic          underrun;

    pcm_pwm_modulator #(
        .SAMPLE_W  (SW),
        .REPEAT    (RP),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .s_data_i     (sData),
        .s_valid_i    (sValid),
        .s_ready_o    (sReady),
        .aud_pwm_o    (audPwm),
        .aud_sd_o     (audSd),
        .sample_tick_o(sampleTick),
        .underrun_o   (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          tickCnt   = 0;
    bit          monActive = 1'b0;
    int          monPhase  = 0;
    int          monAcc    = 0;
    int unsigned expq[$];

    // Expected high clocks per period for a pushed sample.
    function automatic int unsigned toHigh(input logic [7:0] d);
`ifdef PCM_PWM_SIGNED_EN
        return 32'({~d[7], d[6:0]});
`else
        return 32'(d);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; samples outputs on the falling edge and scores completed PWM periods.
    task automatic stepCycle();
        @(negedge clk);
        cyc++;
        if (sampleTick) tickCnt++;
        if (monActive) begin
            monAcc += int'(audPwm);
            monPhase++;
            if (monPhase == PERIOD) begin
                if (expq.size() == 0) checkOutput("period_unexpected", monAcc, 32'hFFFF_FFFF);
                else checkOutput("period_high", monAcc, expq.pop_front());
                monAcc   = 0;
                monPhase = 0;
                if (!audSd) monActive = 1'b0;
            end
        end else if (sampleTick) begin
            monActive = 1'b1;
            monAcc    = 0;
            monPhase  = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, output int acceptCyc);
        bit done;
        done      = 1'b0;
        acceptCyc = -1;
        sData     = d;
        sValid    = 1'b1;
        for (int g = 0; g < 2000 && !done; g++) begin
            #1;
            if (sReady) begin
                stepCycle();
                done      = 1'b1;
                acceptCyc = cyc;
            end else begin
                stepCycle();
            end
        end
        sValid = 1'b0;
        checkOutput("push_accept", 32'(done), 1);
        if (done) repeat (RP) expq.push_back(toHigh(d));
    endtask

    task automatic waitDrain(input string tag, input int limit);
        for (int g = 0; g < limit && expq.size() != 0; g++) stepCycle();
        checkOutput(tag, expq.size(), 0);
    endtask

    task automatic waitIdle(input string tag, input int limit);
        for (int g = 0; g < limit && monActive; g++) stepCycle();
        checkOutput(tag, 32'(monActive), 0);
    endtask

    int acc[6];
    int a;
    int hi;

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        sValid = 1'b1;
        sData  = 8'h55;

        // Reset held with enable and valid asserted.
        repeat (3) begin
            stepCycle();
            checkOutput("rst_s_ready", 32'(sReady), 0);
        end
        checkOutput("rst_pwm", 32'(audPwm), 0);
        checkOutput("rst_sd", 32'(audSd), 0);
        checkOutput("rst_tick", 32'(sampleTick), 0);
        checkOutput("rst_underrun", 32'(underrun), 0);
        rst    = 1'b0;
        en     = 1'b0;
        sValid = 1'b0;
        stepCycle();
        checkOutput("idle_sd", 32'(audSd), 0);

        // Duty patterns, first-edge latency, underrun and disable mid-period.
        $display("[TB] duty / underrun / disable");
        tickCnt = 0;
        en = 1'b1;
        stepCycle();
        checkOutput("prime_sd", 32'(audSd), 1);
        checkOutput("prime_pwm", 32'(audPwm), 0);
        applyStimulus(8'h40, a);
        stepCycle();
        checkOutput("first_tick", 32'(sampleTick), 1);
        checkOutput("first_edge_lat1", 32'(audPwm), 0);
        stepCycle();
        checkOutput("first_edge_lat2", 32'(audPwm), 1);
        applyStimulus(8'h00, a);
        applyStimulus(8'hFF, a);
        checkOutput("no_underrun_yet", 32'(underrun), 0);
        repeat (RP) expq.push_back(128);
        waitDrain("drain_duty", 10 * PERIOD);
        checkOutput("underrun_set", 32'(underrun), 1);
        checkOutput("duty_ticks", tickCnt, 3);
        repeat (RP) expq.push_back(128);
        repeat (100) stepCycle();
        checkOutput("underrun_sticky", 32'(underrun), 1);
        checkOutput("pre_disable_sd", 32'(audSd), 1);
        en = 1'b0;
        waitIdle("disable_idle", 3 * PERIOD);
        checkOutput("disable_sd", 32'(audSd), 0);
        checkOutput("disable_pwm", 32'(audPwm), 0);
        checkOutput("disable_queue", expq.size(), 0);
        stepCycle();
        checkOutput("underrun_cleared", 32'(underrun), 0);
        hi = 0;
        repeat (300) begin
            stepCycle();
            hi += int'(audPwm);
        end
        checkOutput("idle_no_pulse", hi, 0);

        // Back-to-back pushes: five accepted, sixth waits for the next boundary pop.
        $display("[TB] backpressure");
        tickCnt = 0;
        en = 1'b1;
        stepCycle();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'((i + 1) * 16), acc[i]);
            if (i == 4) checkOutput("bp_full_ready", 32'(sReady), 0);
        end
        for (int i = 1; i < 5; i++) checkOutput("bp_gap", acc[i] - acc[0], i);
        checkOutput("bp_resume", acc[5] - acc[0], 2 * PERIOD + 2);
        repeat (RP) expq.push_back(128);
        waitDrain("drain_bp", 16 * PERIOD);
        checkOutput("bp_underrun", 32'(underrun), 1);
        checkOutput("bp_ticks", tickCnt, 6);
        repeat (RP) expq.push_back(128);
        en = 1'b0;
        waitIdle("bp_idle", 3 * PERIOD);
        checkOutput("bp_sd", 32'(audSd), 0);

        // Signed-boundary codes (interpretation depends on build).
        $display("[TB] sign codes");
        tickCnt = 0;
        en = 1'b1;
        stepCycle();
        applyStimulus(8'h80, a);
        applyStimulus(8'h00, a);
        applyStimulus(8'h7F, a);
        repeat (RP) expq.push_back(128);
        waitDrain("drain_sign", 10 * PERIOD);
        checkOutput("sign_ticks", tickCnt, 3);
        repeat (RP) expq.push_back(128);
        en = 1'b0;
        waitIdle("sign_idle", 3 * PERIOD);

        // Reset in the middle of a period.
        $display("[TB] mid-period reset");
        en = 1'b1;
        stepCycle();
        applyStimulus(8'hFF, a);
        repeat (50) stepCycle();
        checkOutput("pre_rst_pwm", 32'(audPwm), 1);
        checkOutput("pre_rst_sd", 32'(audSd), 1);
        rst = 1'b1;
        stepCycle();
        checkOutput("mid_rst_pwm", 32'(audPwm), 0);
        checkOutput("mid_rst_sd", 32'(audSd), 0);
        checkOutput("mid_rst_ready", 32'(sReady), 0);
        monActive = 1'b0;
        expq.delete();
        rst = 1'b0;
        en  = 1'b0;
        stepCycle();
        checkOutput("post_rst_sd", 32'(audSd), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
